mole_popup_animator: RTL and testbench

- Animates the mole sprite rising out of and sinking back into its hole.
- Watches the game-state FSM's display_state and produces a per-frame sprite height, sprite selection and location for the video overlay.
- Returns the one-cycle popup_done pulse that the game-state FSM waits on in MOLE_ASCENDING, HAPPY_MOLE_DESCENDING and DEAD_MOLE_DESCENDING.
- Sits between the game-state FSM (upstream) and the mole sprite renderer (downstream).

---
 rtl/game_pkg.sv | 46 ++++
 rtl/frame_step_prescaler.sv | 30 +++
 rtl/mole_popup_animator.sv | 161 ++++++++++++++++
 tb/tb_mole_popup_animator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - game-state codes, sprite codes and animator states
// Purpose: constants and types shared by the game-state FSM and the mole popup animator.
// Ports:   none (package).
package game_pkg;

   // Game-state FSM codes observed on display_state
   localparam logic [3:0] GS_IDLE               = 4'd0;
   localparam logic [3:0] GS_MOLE_MISSED        = 4'd5;
   localparam logic [3:0] GS_MOLE_WHACKED       = 4'd6;
   localparam logic [3:0] GS_GAME_OVER          = 4'd8;
   localparam logic [3:0] GS_MOLE_MISSED_SOUND  = 4'd9;
   localparam logic [3:0] GS_MOLE_WHACKED_SOUND = 4'd10;
   localparam logic [3:0] GS_ASCENDING          = 4'd13;
   localparam logic [3:0] GS_HAPPY_DESC         = 4'd14;
   localparam logic [3:0] GS_DEAD_DESC          = 4'd15;

   typedef enum logic [1:0] {
      SPR_NONE   = 2'd0,
      SPR_NORMAL = 2'd1,
      SPR_HAPPY  = 2'd2,
      SPR_DEAD   = 2'd3
   } sprite_e;

   typedef enum logic [1:0] {
      A_IDLE = 2'd0,
      A_RISE = 2'd1,
      A_HOLD = 2'd2,
      A_FALL = 2'd3
   } anim_state_e;

   // Sprite shown while the mole is held up (and carried into the descent)
   function automatic sprite_e hold_sprite(input logic [3:0] ds);
      sprite_e spr;
      case (ds)
         GS_MOLE_MISSED, GS_MOLE_MISSED_SOUND, GS_HAPPY_DESC:  spr = SPR_HAPPY;
         GS_MOLE_WHACKED, GS_MOLE_WHACKED_SOUND, GS_DEAD_DESC: spr = SPR_DEAD;
         default:                                              spr = SPR_NORMAL;
      endcase
      return spr;
   endfunction

   function automatic logic is_abort(input logic [3:0] ds);
      return (ds == GS_IDLE) || (ds == GS_GAME_OVER);
   endfunction

endpackage

// File: rtl/frame_step_prescaler.sv
// rtl/frame_step_prescaler.sv - divides frame ticks down to animation step ticks
// Purpose: counts frame_tick pulses and fires step_tick on every FRAMES_PER_STEP-th one.
// Ports:   clk_i, reset_i (sync, active-high), clear_i (restart count, swallows a
//          coincident tick), frame_tick_i (one pulse per frame), step_tick_o (comb pulse).
module frame_step_prescaler #(
   parameter int unsigned FRAMES_PER_STEP = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic frame_tick_i,
   output logic step_tick_o
);

   localparam logic [3:0] LAST = 4'(FRAMES_PER_STEP - 1);

   logic [3:0] cnt_q;

   // A tick that lands on a clear cycle is discarded, not counted
   assign step_tick_o = frame_tick_i && !clear_i && (cnt_q == LAST);

   always_ff @(posedge clk_i) begin
      if (reset_i || clear_i) begin
         cnt_q <= '0;
      end else if (frame_tick_i) begin
         cnt_q <= (cnt_q == LAST) ? 4'd0 : cnt_q + 4'd1;
      end
   end

endmodule

// File: rtl/mole_popup_animator.sv
// rtl/mole_popup_animator.sv - mole sprite rise/hold/fall animation sequencer
// Purpose: follows the game-state FSM and produces per-frame sprite height, sprite
//          selection and hole index, plus a one-cycle popup_done on animation completion.
// Ports:   clk_i, reset_i (sync, active-high), frame_tick_i, display_state_i[3:0],
//          mole_location_i[2:0] -> mole_height_o[HEIGHT_W-1:0], mole_visible_o,
//          sprite_sel_o[1:0], anim_location_o[2:0], popup_done_o.
module mole_popup_animator
   import game_pkg::*;
#(
   parameter int unsigned FRAMES_PER_STEP = 2,
   parameter int unsigned STEP_PX         = 4,
   parameter int unsigned MAX_HEIGHT      = 64,
   parameter int unsigned HEIGHT_W        = 7
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                frame_tick_i,
   input  logic [3:0]          display_state_i,
   input  logic [2:0]          mole_location_i,
   output logic [HEIGHT_W-1:0] mole_height_o,
   output logic                mole_visible_o,
   output logic [1:0]          sprite_sel_o,
   output logic [2:0]          anim_location_o,
   output logic                popup_done_o
);

   localparam int unsigned HW1 = HEIGHT_W + 1;
   localparam logic [HEIGHT_W:0] STEP_W = HW1'(STEP_PX);
   localparam logic [HEIGHT_W:0] MAX_W  = HW1'(MAX_HEIGHT);

   anim_state_e         state_q;
   logic [HEIGHT_W-1:0] height_q;
   sprite_e             sprite_q;
   logic [2:0]          loc_q;
   logic                done_q;

   logic                step_tick;
   logic                abort;
   logic                disp_trans;
   logic [HEIGHT_W:0]   h_sum;
   logic [HEIGHT_W:0]   h_diff;
   logic [HEIGHT_W-1:0] h_up;
   logic [HEIGHT_W-1:0] h_dn;

   // Height arithmetic one bit wider so the clamp sees overflow instead of wrapping
   always_comb begin
      h_sum  = {1'b0, height_q} + STEP_W;
      h_diff = {1'b0, height_q} - STEP_W;
      h_up   = (h_sum >= MAX_W) ? MAX_W[HEIGHT_W-1:0] : h_sum[HEIGHT_W-1:0];
      h_dn   = ({1'b0, height_q} <= STEP_W) ? '0 : h_diff[HEIGHT_W-1:0];
   end

   // State changes that do not depend on step_tick; these restart the prescaler.
   // Tick-driven changes need no clear since the prescaler has just wrapped.
   always_comb begin
      abort      = is_abort(display_state_i);
      disp_trans = 1'b0;
      case (state_q)
         A_IDLE:  disp_trans = (display_state_i == GS_ASCENDING);
         A_RISE:  disp_trans = abort || (display_state_i != GS_ASCENDING);
         A_HOLD:  disp_trans = abort || (display_state_i == GS_HAPPY_DESC)
                                     || (display_state_i == GS_DEAD_DESC);
         A_FALL:  disp_trans = abort || (height_q == '0);
         default: disp_trans = 1'b1;
      endcase
   end

   frame_step_prescaler #(
      .FRAMES_PER_STEP (FRAMES_PER_STEP)
   ) u_prescaler (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .clear_i      (disp_trans),
      .frame_tick_i (frame_tick_i),
      .step_tick_o  (step_tick)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= A_IDLE;
         height_q <= '0;
         sprite_q <= SPR_NONE;
         loc_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            A_IDLE: begin
               height_q <= '0;
               sprite_q <= SPR_NONE;
               if (display_state_i == GS_ASCENDING) begin
                  state_q  <= A_RISE;
                  loc_q    <= mole_location_i;
                  sprite_q <= SPR_NORMAL;
               end
            end
            A_RISE: begin
               if (abort) begin
                  state_q  <= A_IDLE;
                  height_q <= '0;
                  sprite_q <= SPR_NONE;
               end else if (display_state_i != GS_ASCENDING) begin
                  // Early stomp: freeze where we are, no completion pulse
                  state_q  <= A_HOLD;
                  sprite_q <= hold_sprite(display_state_i);
               end else if (step_tick) begin
                  height_q <= h_up;
                  if ({1'b0, h_up} == MAX_W) begin
                     done_q  <= 1'b1;
                     state_q <= A_HOLD;
                  end
               end
            end
            A_HOLD: begin
               if (abort) begin
                  state_q  <= A_IDLE;
                  height_q <= '0;
                  sprite_q <= SPR_NONE;
               end else begin
                  sprite_q <= hold_sprite(display_state_i);
                  if ((display_state_i == GS_HAPPY_DESC) ||
                      (display_state_i == GS_DEAD_DESC)) begin
                     state_q <= A_FALL;
                  end
               end
            end
            A_FALL: begin
               if (abort) begin
                  state_q  <= A_IDLE;
                  height_q <= '0;
                  sprite_q <= SPR_NONE;
               end else if (height_q == '0) begin
                  // Nothing left to sink: complete without waiting for a tick
                  done_q   <= 1'b1;
                  sprite_q <= SPR_NONE;
                  state_q  <= A_IDLE;
               end else if (step_tick) begin
                  height_q <= h_dn;
                  if (h_dn == '0) begin
                     done_q   <= 1'b1;
                     sprite_q <= SPR_NONE;
                     state_q  <= A_IDLE;
                  end
               end
            end
            default: begin
               state_q  <= A_IDLE;
               height_q <= '0;
               sprite_q <= SPR_NONE;
            end
         endcase
      end
   end

   assign mole_height_o   = height_q;
   assign mole_visible_o  = (height_q != '0);
   assign sprite_sel_o    = sprite_q;
   assign anim_location_o = loc_q;
   assign popup_done_o    = done_q;

endmodule

// File: tb/tb_mole_popup_animator.sv
// tb/tb_mole_popup_animator.sv - scoreboard bench for mole_popup_animator
module tb_mole_popup_animator;

   typedef struct packed {
      logic [6:0] h;
      logic [1:0] spr;
      logic [2:0] loc;
      logic       done;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic [3:0] display_state = 4'd0;
   logic [2:0] mole_location = 3'd0;
   logic [3:0] display5 = 4'd0;
   logic [2:0] loc5 = 3'd0;

   logic [6:0] mole_height,   mole_height5;
   logic       mole_visible,  mole_visible5;
   logic [1:0] sprite_sel,    sprite_sel5;
   logic [2:0] anim_location, anim_location5;
   logic       popup_done,    popup_done5;

   int  checks = 0;
   int  errors = 0;
   bit  mon_en = 1'b0;
   ev_t q[$];
   ev_t q5[$];

   always #5 clk = ~clk;

   mole_popup_animator #(
      .FRAMES_PER_STEP (2), .STEP_PX (4), .MAX_HEIGHT (64), .HEIGHT_W (7)
   ) u_dut (
      .clk_i (clk), .reset_i (reset), .frame_tick_i (frame_tick),
      .display_state_i (display_state), .mole_location_i (mole_location),
      .mole_height_o (mole_height), .mole_visible_o (mole_visible),
      .sprite_sel_o (sprite_sel), .anim_location_o (anim_location),
      .popup_done_o (popup_done)
   );

   mole_popup_animator #(
      .FRAMES_PER_STEP (2), .STEP_PX (5), .MAX_HEIGHT (64), .HEIGHT_W (7)
   ) u_dut5 (
      .clk_i (clk), .reset_i (reset), .frame_tick_i (frame_tick),
      .display_state_i (display5), .mole_location_i (loc5),
      .mole_height_o (mole_height5), .mole_visible_o (mole_visible5),
      .sprite_sel_o (sprite_sel5), .anim_location_o (anim_location5),
      .popup_done_o (popup_done5)
   );

   // Monitor for the STEP_PX=4 instance: any change of height/sprite or a pulse is an event
   logic [6:0] ph = '0;
   logic [1:0] ps = '0;
   logic       pd = 1'b0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (mole_height != ph || sprite_sel != ps || popup_done) begin
            ev_t got, e;
            got = {mole_height, sprite_sel, anim_location, popup_done};
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event dut4: h=%0d spr=%0d loc=%0d done=%0b, required no event",
                        mole_height, sprite_sel, anim_location, popup_done);
            end else begin
               e = q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL event dut4: got h=%0d spr=%0d loc=%0d done=%0b, required h=%0d spr=%0d loc=%0d done=%0b",
                           got.h, got.spr, got.loc, got.done, e.h, e.spr, e.loc, e.done);
               end
            end
         end
         checks++;
         if (mole_visible !== (mole_height != 0)) begin
            errors++;
            $display("FAIL visible dut4: got %0b, required %0b", mole_visible, mole_height != 0);
         end
         if (popup_done && pd) begin
            checks++;
            errors++;
            $display("FAIL double_pulse dut4: got 2 consecutive, required 1");
         end
      end
      ph = mole_height;
      ps = sprite_sel;
      pd = popup_done;
   end

   // Monitor for the STEP_PX=5 instance
   logic [6:0] ph5 = '0;
   logic [1:0] ps5 = '0;
   logic       pd5 = 1'b0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (mole_height5 != ph5 || sprite_sel5 != ps5 || popup_done5) begin
            ev_t got, e;
            got = {mole_height5, sprite_sel5, anim_location5, popup_done5};
            checks++;
            if (q5.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event dut5: h=%0d spr=%0d loc=%0d done=%0b, required no event",
                        mole_height5, sprite_sel5, anim_location5, popup_done5);
            end else begin
               e = q5.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL event dut5: got h=%0d spr=%0d loc=%0d done=%0b, required h=%0d spr=%0d loc=%0d done=%0b",
                           got.h, got.spr, got.loc, got.done, e.h, e.spr, e.loc, e.done);
               end
            end
         end
         if (popup_done5 && pd5) begin
            checks++;
            errors++;
            $display("FAIL double_pulse dut5: got 2 consecutive, required 1");
         end
      end
      ph5 = mole_height5;
      ps5 = sprite_sel5;
      pd5 = popup_done5;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Every required event must have been consumed by now
   task automatic drain(input string name);
      checks++;
      if (q.size() != 0 || q5.size() != 0) begin
         errors++;
         $display("FAIL drain_%s: got %0d/%0d pending events, required 0/0", name, q.size(), q5.size());
         q.delete();
         q5.delete();
      end
   endtask

   task automatic push(input bit five, input ev_t x);
      if (five) q5.push_back(x);
      else      q.push_back(x);
   endtask

   task automatic do_tick(input bit five, input bit e, input ev_t x);
      if (e) push(five, x);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      drain("tick");
   endtask

   task automatic set_disp(input bit five, input logic [3:0] d, input bit e, input ev_t x,
                           input bit tk);
      if (e) push(five, x);
      if (five) display5 = d;
      else      display_state = d;
      frame_tick = tk;
      step();
      frame_tick = 1'b0;
      step();
      drain("disp");
   endtask

   // n frame ticks; every second one is a height step with hand-derived target
   task automatic run_ticks(input bit five, input int n, input int h0, input bit up,
                            input int stp, input int maxh, input logic [1:0] spr,
                            input logic [2:0] loc);
      int  h;
      ev_t x;
      bit  e;
      h = h0;
      for (int i = 1; i <= n; i++) begin
         e = 1'b0;
         x = '0;
         if (i % 2 == 0) begin
            if (up) h = (h + stp > maxh) ? maxh : h + stp;
            else    h = (h < stp) ? 0 : h - stp;
            x.h    = 7'(h);
            x.spr  = (!up && h == 0) ? 2'd0 : spr;
            x.loc  = loc;
            x.done = up ? (h == maxh) : (h == 0);
            e      = 1'b1;
         end
         do_tick(five, e, x);
      end
   endtask

   initial begin
      ev_t none;
      none = '0;

      // Reset state
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("reset_height",  mole_height,   0);
      chk("reset_visible", mole_visible,  0);
      chk("reset_sprite",  sprite_sel,    0);
      chk("reset_loc",     anim_location, 0);
      chk("reset_done",    popup_done,    0);
      mon_en = 1'b1;

      // Normal rise to 64 at hole 5, then happy descent
      mole_location = 3'd5;
      set_disp(0, 4'd13, 1, '{h: 7'd0, spr: 2'd1, loc: 3'd5, done: 1'b0}, 0);
      run_ticks(0, 32, 0, 1, 4, 64, 2'd1, 3'd5);
      chk("rise_loc", anim_location, 5);
      set_disp(0, 4'd9, 1, '{h: 7'd64, spr: 2'd2, loc: 3'd5, done: 1'b0}, 0);
      set_disp(0, 4'd14, 0, none, 0);
      run_ticks(0, 32, 64, 0, 4, 64, 2'd2, 3'd5);
      set_disp(0, 4'd0, 0, none, 0);

      // Early stomp at 20 with a coincident frame tick, then dead descent
      mole_location = 3'd3;
      set_disp(0, 4'd13, 1, '{h: 7'd0, spr: 2'd1, loc: 3'd3, done: 1'b0}, 0);
      run_ticks(0, 10, 0, 1, 4, 64, 2'd1, 3'd3);
      do_tick(0, 0, none);
      set_disp(0, 4'd6, 1, '{h: 7'd20, spr: 2'd3, loc: 3'd3, done: 1'b0}, 1);
      do_tick(0, 0, none);
      do_tick(0, 0, none);
      do_tick(0, 0, none);
      set_disp(0, 4'd15, 0, none, 0);
      run_ticks(0, 10, 20, 0, 4, 64, 2'd3, 3'd3);
      set_disp(0, 4'd0, 0, none, 0);

      // Abort via game over at height 36
      mole_location = 3'd2;
      set_disp(0, 4'd13, 1, '{h: 7'd0, spr: 2'd1, loc: 3'd2, done: 1'b0}, 0);
      run_ticks(0, 18, 0, 1, 4, 64, 2'd1, 3'd2);
      set_disp(0, 4'd8, 1, '{h: 7'd0, spr: 2'd0, loc: 3'd2, done: 1'b0}, 0);
      set_disp(0, 4'd0, 0, none, 0);

      // Reset at height 40
      mole_location = 3'd6;
      set_disp(0, 4'd13, 1, '{h: 7'd0, spr: 2'd1, loc: 3'd6, done: 1'b0}, 0);
      run_ticks(0, 20, 0, 1, 4, 64, 2'd1, 3'd6);
      push(0, '{h: 7'd0, spr: 2'd0, loc: 3'd0, done: 1'b0});
      reset = 1'b1;
      display_state = 4'd0;
      step();
      reset = 1'b0;
      step();
      drain("reset");

      // Clamp with STEP_PX=5: 60 -> 64, not 65
      loc5 = 3'd1;
      set_disp(1, 4'd13, 1, '{h: 7'd0, spr: 2'd1, loc: 3'd1, done: 1'b0}, 0);
      run_ticks(1, 26, 0, 1, 5, 64, 2'd1, 3'd1);
      chk("clamp_height", mole_height5, 64);
      set_disp(1, 4'd0, 1, '{h: 7'd0, spr: 2'd0, loc: 3'd1, done: 1'b0}, 0);

      repeat (3) step();
      drain("final");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
